// File: rtl/l1_instr_fetch_refill.sv
// Instruction-fetch initiator: looks up the L1, refills a whole aligned line from memory on a miss.
// Optional FETCH_STATS_EN adds saturating hit/miss counters (hit_count, miss_count).
module l1_instr_fetch_refill #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FETCH_STATS_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  input  logic              pc_req_valid,
  input  logic [ADDR_W-1:0] pc_req_addr,
  output logic              pc_req_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic              l1_mode,
  output logic [ADDR_W-1:0] l1_read_addr,
  input  logic [DATA_W-1:0] l1_read_value,
  input  logic              l1_read_hit,
  output logic [ADDR_W-1:0] l1_write_addr,
  output logic [DATA_W-1:0] l1_write_value,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LINE_WORDS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] MISS_REQ  = 3'd2;
  localparam logic [2:0] MISS_WAIT = 3'd3;
  localparam logic [2:0] FILL      = 3'd4;
  localparam logic [2:0] RESP      = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] crit_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              last_word;

  // Line is aligned, so base + cnt never carries out of the offset bits.
  assign cur_addr  = base + ADDR_W'(cnt);
  assign last_word = (cnt == LAST_CNT);

  assign pc_req_ready   = (state == IDLE) && !reset;
  assign l1_mode        = (state == FILL);
  assign l1_write_addr  = cur_addr;
  assign l1_write_value = word_q;
  assign mem_req_valid  = (state == MISS_REQ);
  assign mem_req_addr   = cur_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      base         <= '0;
      cnt          <= '0;
      word_q       <= '0;
      crit_q       <= '0;
      l1_read_addr <= '0;
      instr_data   <= '0;
      instr_valid  <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_req_valid) begin
            addr_q       <= pc_req_addr;
            l1_read_addr <= pc_req_addr;
            state        <= LOOKUP;
          end
        end
        LOOKUP: begin
          // Hits also go through RESP so both paths share one output register.
          if (l1_read_hit) begin
            crit_q <= l1_read_value;
            state  <= RESP;
          end else begin
            base  <= addr_q & ~OFS_MASK;
            cnt   <= '0;
            state <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (mem_resp_valid) begin
            word_q <= mem_resp_data;
            if (cur_addr == addr_q) crit_q <= mem_resp_data;
            state <= FILL;
          end
        end
        FILL: begin
          if (last_word) begin
            state <= RESP;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= MISS_REQ;
          end
        end
        RESP: begin
          instr_data  <= crit_q;
          instr_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (l1_read_hit) hit_count  <= sat_inc(hit_count);
      else             miss_count <= sat_inc(miss_count);
    end
  end
`endif

endmodule
